sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
- Sequencer for the Sobel front end. Accepts the raw pixel stream and drives the shift enable of the two cascaded line delays and the 3x3 column shift registers.
- Tracks column and row position, and suppresses window output while the buffers prime.
- Flags the first and last valid window of each line and frame, and applies backpressure from the Sobel core.

Parameters:
- LINE_WIDTH, 1920, active pixels per line; must be >= 3.
- FRAME_HEIGHT, 1080, active lines per frame; must be >= 3.
- COL_W, $clog2(LINE_WIDTH), column counter width (derived, not overridden).
- ROW_W, $clog2(FRAME_HEIGHT), row counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_sof  in  1  start of frame, qualified by in_valid; marks pixel (0,0).
- in_ready  out  1  controller accepts the pixel this cycle.
- lb_shift_en  out  1  shift enable to line delays and window registers; equals in_valid & in_ready.
- win_valid  out  1  3x3 window centred on a valid output pixel is present.
- win_ready  in  1  Sobel core consumes the window.
- win_col  out  COL_W  column of the newest window pixel (2..LINE_WIDTH-1).
- win_row  out  ROW_W  row of the newest window pixel (2..FRAME_HEIGHT-1).
- win_sol  out  1  first window of a line (win_col==2).
- win_eol  out  1  last window of a line (win_col==LINE_WIDTH-1).
- win_eof  out  1  last window of the frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0, except in_ready=1.
  - State IDLE; col=0, row=0.
- Handshake:
  - in_ready = !win_valid | win_ready. This gives a single-slot output stage.
  - A pixel is accepted when in_valid & in_ready.
  - lb_shift_en is combinational, identical to the accept condition.
- Latency:
  - win_* is registered and appears 1 cycle after the accepting edge, aligned with the line-delay read data.
  - Once raised, win_valid holds with all win_* fields stable until win_ready=1.
- Counters:
  - col increments on accept and wraps LINE_WIDTH-1 -> 0.
  - On that wrap, row increments and wraps FRAME_HEIGHT-1 -> 0.
- FSM:
  - IDLE: pixels without in_sof are accepted but discarded (lb_shift_en=0, in_ready=1). An accepted in_sof loads col=1, row=0, drives lb_shift_en=1 and moves to PRIME.
  - PRIME: rows 0 and 1; no win_valid. Moves to RUN when the pixel at col=LINE_WIDTH-1, row=1 is accepted.
  - RUN: rows 2..FRAME_HEIGHT-1.
    - An accepted pixel with col>=2 sets win_valid next cycle; col<2 sets nothing.
    - The accept at (LINE_WIDTH-1, FRAME_HEIGHT-1) sets win_eof together with win_eol, then goes to IDLE.
- Width rules: counters are unsigned with no overflow, because wrap is explicit at LINE_WIDTH-1 / FRAME_HEIGHT-1 (not the power of two).
- Boundary cases:
  - in_sof in PRIME or RUN restarts the frame: col=1, row=0, state PRIME. Any pending win_valid is dropped in the same cycle.
  - in_sof with in_valid=0 is ignored.
  - Backpressure in PRIME: win_valid is never set, so in_ready stays 1.
  - Reset asserted mid-frame clears everything immediately. The line-delay contents are not cleared; they are overwritten during PRIME.

Optional Feature:
- Macro: SOBEL_WIN_CTRL_STATS_EN.
- Defined: adds outputs frame_cnt (16 bit, increments on each win_eof accept, wraps) and sof_err (1-cycle pulse when in_sof arrives outside IDLE, i.e. a truncated frame). Both reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg:
  - FSM state enum (IDLE, PRIME, RUN).
  - Default LINE_WIDTH and FRAME_HEIGHT constants.
  - Function for the minimum-size check.
- Natural sub-module: sobel_pos_cnt, the column/row wrap counter pair with enable and load, reusable by the output formatter.

Test Plan:
- LINE_WIDTH=8, FRAME_HEIGHT=4, full-rate stream with sof at (0,0), win_ready=1:
  - No win_valid for the first 16 accepts.
  - win_valid asserted for 12 cycles total, win_col cycling 2..7.
  - win_sol and win_eol on col 2 and col 7.
  - win_eof on the 32nd pixel, then busy=0.
- win_ready=0 for 5 cycles while win_valid=1 at (4,2):
  - in_ready=0 and lb_shift_en=0 throughout.
  - win_col=4 and win_row=2 stable.
  - Resume without loss or duplication.
- 10 pixels without sof in IDLE -> lb_shift_en never asserted and busy=0; first sof starts PRIME.
- sof injected at (3,2) in RUN -> win_valid deasserts next cycle, restart in PRIME with col=1 and row=0 (sof_err=1 when STATS_EN is defined).
- rst_n pulsed low asynchronously mid-RUN -> all outputs 0 and in_ready=1 immediately; the next sof frame completes correctly.
- Two back-to-back frames with STATS_EN defined -> frame_cnt reads 2 and win_eof is seen exactly twice.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared FSM state type, default frame geometry and the minimum-size check
// for the Sobel window sequencer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } win_state_t;

  localparam int DEF_LINE_WIDTH   = 1920;
  localparam int DEF_FRAME_HEIGHT = 1080;
  localparam int MIN_DIM          = 3;

  function automatic bit dims_ok(input int line_width, input int frame_height);
    return (line_width >= MIN_DIM) && (frame_height >= MIN_DIM);
  endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle of the Sobel window sequencer.
// frame_cnt and sof_err exist only when SOBEL_WIN_CTRL_STATS_EN is defined.
interface sobel_window_ctrl_if
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT
) ();

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);

  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             lb_shift_en;
  logic             win_valid;
  logic             win_ready;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             win_sol;
  logic             win_eol;
  logic             win_eof;
  logic             busy;
`ifdef SOBEL_WIN_CTRL_STATS_EN
  logic [15:0]      frame_cnt;
  logic             sof_err;
`endif

  // master is the sequencer itself; slave is the pixel source / Sobel core side
`ifdef SOBEL_WIN_CTRL_STATS_EN
  modport master (
    input  in_valid, in_sof, win_ready,
    output in_ready, lb_shift_en, win_valid, win_col, win_row,
           win_sol, win_eol, win_eof, busy, frame_cnt, sof_err
  );
  modport slave (
    output in_valid, in_sof, win_ready,
    input  in_ready, lb_shift_en, win_valid, win_col, win_row,
           win_sol, win_eol, win_eof, busy, frame_cnt, sof_err
  );
`else
  modport master (
    input  in_valid, in_sof, win_ready,
    output in_ready, lb_shift_en, win_valid, win_col, win_row,
           win_sol, win_eol, win_eof, busy
  );
  modport slave (
    output in_valid, in_sof, win_ready,
    input  in_ready, lb_shift_en, win_valid, win_col, win_row,
           win_sol, win_eol, win_eof, busy
  );
`endif

endinterface

// File: rtl/sobel_pos_cnt.sv
// Column/row position counter pair with explicit wrap at the active frame size.
// A load takes priority over the count enable.
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            load,
  input  logic [$clog2(LINE_WIDTH)-1:0]   load_col,
  input  logic [$clog2(FRAME_HEIGHT)-1:0] load_row,
  output logic [$clog2(LINE_WIDTH)-1:0]   col,
  output logic [$clog2(FRAME_HEIGHT)-1:0] row,
  output logic                            col_last,
  output logic                            row_last
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_HEIGHT - 1);

  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);

  // Wrap is at the frame size, not the counter's power-of-two range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= load_col;
      row <= load_row;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel front-end sequencer: line-delay shift enable, priming, window flags.
// Optional statistics outputs are built when SOBEL_WIN_CTRL_STATS_EN is defined.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_window_ctrl_if.master bus
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);
  localparam logic [COL_W-1:0] COL_FIRST_WIN  = COL_W'(2);
  localparam logic [COL_W-1:0] COL_SOF_LOAD   = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_PRIME_LAST = ROW_W'(1);

  if (!dims_ok(LINE_WIDTH, FRAME_HEIGHT)) begin : g_bad_dims
    $error("sobel_window_ctrl: LINE_WIDTH and FRAME_HEIGHT must be >= 3");
  end

  win_state_t       state;
  win_state_t       state_next;
  logic             in_ready;
  logic             accept;
  logic             shift;
  logic             cnt_en;
  logic             cnt_load;
  logic             set_win;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;

  logic             win_valid_q;
  logic [COL_W-1:0] win_col_q;
  logic [ROW_W-1:0] win_row_q;
  logic             win_sol_q;
  logic             win_eol_q;
  logic             win_eof_q;

  // Single-slot output stage: a new pixel is taken only if the slot frees this cycle
  assign in_ready = !win_valid_q || bus.win_ready;
  assign accept   = bus.in_valid && in_ready;

  sobel_pos_cnt #(
    .LINE_WIDTH   (LINE_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_pos_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_col (COL_SOF_LOAD),
    .load_row ('0),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // col/row name the pixel about to be accepted; the sof pixel itself is (0,0)
  always_comb begin
    state_next = state;
    shift      = 1'b0;
    cnt_en     = 1'b0;
    cnt_load   = 1'b0;
    set_win    = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (bus.in_sof) begin
            shift      = 1'b1;
            cnt_load   = 1'b1;
            state_next = PRIME;
          end
        end
        PRIME, RUN: begin
          shift = 1'b1;
          if (bus.in_sof) begin
            cnt_load   = 1'b1;
            state_next = PRIME;
          end else begin
            cnt_en = 1'b1;
            if (state == PRIME) begin
              if (col_last && (row == ROW_PRIME_LAST)) state_next = RUN;
            end else begin
              set_win = (col >= COL_FIRST_WIN);
              if (col_last && row_last) state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      win_sol_q   <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end else if (accept) begin
      win_valid_q <= set_win;
      win_sol_q   <= set_win && (col == COL_FIRST_WIN);
      win_eol_q   <= set_win && col_last;
      win_eof_q   <= set_win && col_last && row_last;
      if (set_win) begin
        win_col_q <= col;
        win_row_q <= row;
      end
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.lb_shift_en = shift;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_col     = win_col_q;
  assign bus.win_row     = win_row_q;
  assign bus.win_sol     = win_sol_q;
  assign bus.win_eol     = win_eol_q;
  assign bus.win_eof     = win_eof_q;
  assign bus.busy        = (state != IDLE);

`ifdef SOBEL_WIN_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic        sof_err_q;

  // A frame counts when its last window is handed to the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      sof_err_q   <= 1'b0;
    end else begin
      if (win_valid_q && win_eof_q && bus.win_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
      sof_err_q <= accept && bus.in_sof && (state != IDLE);
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.sof_err   = sof_err_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on an 8x4 frame: a frame-position
// reference model predicts handshakes and windows; a monitor checks the windows.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int LW        = 8;
  localparam int FH        = 4;
  localparam int COL_W     = $clog2(LW);
  localparam int ROW_W     = $clog2(FH);
  localparam int FRAME_PIX = LW * FH;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             sol;
    logic             eol;
    logic             eof;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sobel_window_ctrl_if #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) bus ();

  sobel_window_ctrl #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  win_t exp_q[$];

  // Reference model: frame membership and linear index of the next pixel
  bit   in_frame      = 1'b0;
  int   pos           = 0;
  bit   pending       = 1'b0;
  bit   sof_err_exp   = 1'b0;
  int   frame_cnt_exp = 0;
  bit   new_win       = 1'b0;
  int   last_col      = 0;
  int   last_row      = 0;
  int   win_seen      = 0;
  int   eof_seen      = 0;
  win_t mon_w;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit r);
    bit   exp_ready;
    bit   acc;
    int   x;
    int   y;
    win_t w;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.win_ready = r;
    #1;
    exp_ready = !pending || r;
    acc       = v && exp_ready;
    checkOutput("in_ready", bus.in_ready, exp_ready);
    checkOutput("lb_shift_en", bus.lb_shift_en, acc && (in_frame || s));
    checkOutput("busy", bus.busy, in_frame);
    checkOutput("win_valid", bus.win_valid, pending);
`ifdef SOBEL_WIN_CTRL_STATS_EN
    checkOutput("sof_err", bus.sof_err, sof_err_exp);
    sof_err_exp = acc && s && in_frame;
`endif
    new_win = 1'b0;
    if (acc) begin
      if (s) begin
        in_frame = 1'b1;
        pos      = 1;
      end else if (in_frame) begin
        x = pos % LW;
        y = pos / LW;
        if (y >= 2 && x >= 2) begin
          w.col = COL_W'(x);
          w.row = ROW_W'(y);
          w.sol = (x == 2);
          w.eol = (x == LW - 1);
          w.eof = (pos == FRAME_PIX - 1);
          exp_q.push_back(w);
          new_win  = 1'b1;
          last_col = x;
          last_row = y;
        end
        pos++;
        if (pos == FRAME_PIX) in_frame = 1'b0;
      end
    end
    pending = acc ? new_win : (pending && !r);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_lb_shift_en", bus.lb_shift_en, 0);
    checkOutput("rst_win_valid", bus.win_valid, 0);
    checkOutput("rst_win_col", bus.win_col, 0);
    checkOutput("rst_win_row", bus.win_row, 0);
    checkOutput("rst_flags", {bus.win_sol, bus.win_eol, bus.win_eof}, 0);
    checkOutput("rst_busy", bus.busy, 0);
`ifdef SOBEL_WIN_CTRL_STATS_EN
    checkOutput("rst_frame_cnt", bus.frame_cnt, 0);
    checkOutput("rst_sof_err", bus.sof_err, 0);
`endif
    exp_q.delete();
    in_frame      = 1'b0;
    pos           = 0;
    pending       = 1'b0;
    sof_err_exp   = 1'b0;
    frame_cnt_exp = 0;
    #5;
    rst_n = 1'b1;
  endtask

  task automatic runFrame(input int ready_pct, input bit stall_at_42, input bit flush);
    int guard;
    int stall_left;
    bit r;
    guard      = 0;
    stall_left = 0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    while (in_frame && guard < 1000) begin
      guard++;
      if (stall_left > 0) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        stall_left--;
      end else begin
        r = ($urandom_range(99) < ready_pct);
        applyStimulus(1'b1, 1'b0, r);
        if (stall_at_42 && new_win && last_col == 4 && last_row == 2) stall_left = 5;
      end
    end
    checkOutput("frame_completes", (guard < 1000), 1);
    if (flush) repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every presented window must equal the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.win_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_window", 1, 0);
        end else begin
          mon_w = exp_q[0];
          checkOutput("win_col", bus.win_col, mon_w.col);
          checkOutput("win_row", bus.win_row, mon_w.row);
          checkOutput("win_sol", bus.win_sol, mon_w.sol);
          checkOutput("win_eol", bus.win_eol, mon_w.eol);
          checkOutput("win_eof", bus.win_eof, mon_w.eof);
          if (bus.win_ready) begin
            void'(exp_q.pop_front());
            win_seen++;
            if (bus.win_eof) eof_seen++;
            if (mon_w.eof) frame_cnt_exp++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_win;
    int base_eof;
    bit v;
    bit s;
    bit r;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.win_ready = 1'b0;

    resetPulse();

    $display("[TB] pixels without sof in IDLE");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] full-rate frame");
    base_win = win_seen;
    base_eof = eof_seen;
    runFrame(100, 1'b0, 1'b1);
    checkOutput("frame_windows", win_seen - base_win, 12);
    checkOutput("frame_eofs", eof_seen - base_eof, 1);
    checkOutput("busy_after_eof", bus.busy, 0);

    $display("[TB] backpressure at (4,2)");
    base_win = win_seen;
    runFrame(100, 1'b1, 1'b1);
    checkOutput("stall_frame_windows", win_seen - base_win, 12);

    $display("[TB] sof restart at (3,2)");
    base_win = win_seen;
    applyStimulus(1'b1, 1'b1, 1'b1);
    while (pos < 2 * LW + 3) applyStimulus(1'b1, 1'b0, 1'b1);
    runFrame(100, 1'b0, 1'b1);
    checkOutput("restart_windows", win_seen - base_win, 13);

    $display("[TB] reset mid-RUN");
    applyStimulus(1'b1, 1'b1, 1'b1);
    while (pos < 2 * LW + 5) applyStimulus(1'b1, 1'b0, 1'b1);
    resetPulse();
    base_win = win_seen;
    runFrame(100, 1'b0, 1'b1);
    checkOutput("post_reset_windows", win_seen - base_win, 12);

    $display("[TB] back-to-back frames");
    resetPulse();
    base_eof = eof_seen;
    runFrame(70, 1'b0, 1'b0);
    runFrame(70, 1'b0, 1'b1);
    checkOutput("b2b_eofs", eof_seen - base_eof, 2);
`ifdef SOBEL_WIN_CTRL_STATS_EN
    checkOutput("frame_cnt", bus.frame_cnt, 2);
`endif

    $display("[TB] randomized traffic");
    repeat (3000) begin
      v = ($urandom_range(99) < 80);
      s = in_frame ? ($urandom_range(299) == 0) : ($urandom_range(19) == 0);
      r = ($urandom_range(99) < 70);
      applyStimulus(v, s, r);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("queue_drained", exp_q.size(), 0);
`ifdef SOBEL_WIN_CTRL_STATS_EN
    checkOutput("frame_cnt_random", bus.frame_cnt, frame_cnt_exp & 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
